drop_sequencer: RTL
===================

# drop_sequencer

Parametrised, clocked successor of the combinational drop-display logic in the baggage-drop design. It sits between the flight-timing path (`t_act`, `t_lim`) and the four-digit seven-segment display and release actuator. It qualifies the drop condition over several consecutive cycles, holds the release pulse for a fixed time, and tracks a finite package magazine. Display words are COLD, _HOT, DROP and DONE.

## Interface
Parameters:
- `T_W`, 16: width of `t_act` / `t_lim`, unsigned.
- `N_PKG`, 4: packages loaded at reset or reload. Legal range is 1..9.
- `QUAL`, 2: number of consecutive qualifying samples required before release. Must be ≥1.
- `HOLD`, 8: cycles that `drop_activated` stays high per release. Must be ≥1.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `rst_n` input 1: synchronous, active-low reset.
- `drop_en` input 1: helicopter is inside the drop area.
- `t_act` input T_W: current estimated descent time.
- `t_lim` input T_W: limit descent time.
- `reload` input 1: refill magazine to `N_PKG`. Single-cycle or level; sampled every edge.
- `seven_seg1..seven_seg4` output 7 each: display digits, left to right. Active-high, bit0 = segment a … bit6 = segment g.
- `drop_activated` output 1: release actuator.
- `pkg_left` output 4: packages remaining.

## Operation
- The qualifying condition is `drop_en==1 && t_act <= t_lim`. The comparison is unsigned and full width.
- The block is a Moore FSM. Outputs are a combinational decode of the state and counter registers only, with no input-to-output path.

States and transitions (evaluated at each rising edge, first match wins):
- **COLD**: entered when `drop_en==0`.
  - Goes to QUAL on the qualifying condition; to DROP instead if `QUAL==1`.
  - Goes to HOT if `drop_en && t_act>t_lim`.
- **HOT**: `drop_en==1` and the limit has not been met.
  - On the qualifying condition, same action as from COLD.
  - On `drop_en==0`, goes to COLD.
- **QUAL**: the qualification counter counts consecutive qualifying samples.
  - When the count reaches `QUAL`, goes to DROP.
  - Any non-qualifying sample clears the counter and goes to COLD or HOT according to the inputs.
- **DROP**:
  - On entry, `pkg_left` decrements.
  - `drop_activated=1` for exactly `HOLD` cycles. Inputs, including `drop_en` falling and `reload`, are ignored.
  - Afterwards goes to EMPTY if `pkg_left==0`, else to WAIT_CLEAR.
- **WAIT_CLEAR**: stays here while `drop_en==1`, so there is one release per pass over the area. Goes to COLD when `drop_en==0`.
- **EMPTY**: terminal state. Never releases.
- **Reload**: `reload==1` in any state except DROP sets `pkg_left=N_PKG` and goes to COLD.

Display patterns:
- COLD: 0111001, 1011100, 0111000, 1011110.
- HOT and QUAL: 0000000, 1110110, 1011100, 1111000 (_HOT).
- DROP and WAIT_CLEAR: 1011110, 1010000, 1011100, 1110011 (DROP).
- EMPTY: 1011110, 1011100, 1010100, 1111001 (DONE).

## Timing
- **Reset** (`rst_n==0` at an edge, including mid-DROP):
  - state COLD, counters 0, `drop_activated=0`, `pkg_left=N_PKG`, display shows COLD.
  - Reset overrides everything.
- **Release latency**: if the qualifying condition is first sampled at edge k, `drop_activated` is high from edge k+QUAL-1 through edge k+QUAL-1+HOLD, and pulse length is exactly `HOLD` cycles. The first qualifying sample is edge 0 of the count.
- **Boundaries**:
  - `t_act==t_lim` qualifies. `t_act==t_lim+1` does not.
  - A non-qualifying sample on the last QUAL cycle aborts with no release.
  - `reload` and the qualifying condition at the same edge: reload wins and the state goes to COLD.
  - `pkg_left` never underflows; release is impossible at 0.

## Configuration
- Macro `DROP_COUNT_DISP_EN`.
- **Defined**: WAIT_CLEAR shows "P-" followed by the count.
  - seg1 = 1110011, seg2 = 1000000, seg3 = 0000000.
  - seg4 = standard digit for `pkg_left`; e.g. 3 = 1001111, 1 = 0000110.
- **Undefined**: WAIT_CLEAR shows DROP.
- All other behaviour is identical in both configurations.

## Test plan
- Reset with defaults, `drop_en=0` → display COLD, `drop_activated=0`, `pkg_left=4`.
- `drop_en=1`, `t_act=100`, `t_lim=50` → _HOT, no release. Then `t_lim=100` held → release at the 2nd qualifying edge, pulse lasting exactly 8 cycles, `pkg_left=3`.
- `t_act<=t_lim` for 1 cycle, then `t_act>t_lim` → no release, back to HOT, `pkg_left` unchanged.
- Drop `drop_en` mid-pulse → pulse still lasts 8 cycles. Keep `drop_en=1` afterwards → no second release until `drop_en=0` then 1 again.
- Four full releases → DONE pattern, further qualifying input ignored. Pulse `reload` → COLD, `pkg_left=4`.
- Assert `rst_n=0` during cycle 3 of DROP → next edge: `drop_activated=0`, COLD, `pkg_left=4`. With `DROP_COUNT_DISP_EN` defined, WAIT_CLEAR after the first drop shows 1110011, 1000000, 0000000, 1001111.

Source files
------------

// File: rtl/drop_sequencer.sv
// Drop sequencer: qualifies the release condition, times the release pulse and tracks the package magazine.
// Optional DROP_COUNT_DISP_EN: WAIT_CLEAR shows "P-" plus the remaining package count.
module drop_sequencer #(
  parameter int unsigned T_W   = 16,
  parameter int unsigned N_PKG = 4,
  parameter int unsigned QUAL  = 2,
  parameter int unsigned HOLD  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           drop_en,
  input  logic [T_W-1:0] t_act,
  input  logic [T_W-1:0] t_lim,
  input  logic           reload,
  output logic [6:0]     seven_seg1,
  output logic [6:0]     seven_seg2,
  output logic [6:0]     seven_seg3,
  output logic [6:0]     seven_seg4,
  output logic           drop_activated,
  output logic [3:0]     pkg_left
);

  localparam int unsigned QW = (QUAL > 1) ? $clog2(QUAL) : 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {
    S_COLD,
    S_HOT,
    S_QUAL,
    S_DROP,
    S_WAIT_CLEAR,
    S_EMPTY
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qual_cnt, qual_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0]    pkg_r, pkg_n;
  logic          qualify;

`ifdef DROP_COUNT_DISP_EN
  function automatic logic [6:0] digit(input logic [3:0] v);
    case (v)
      4'd0:    digit = 7'b0111111;
      4'd1:    digit = 7'b0000110;
      4'd2:    digit = 7'b1011011;
      4'd3:    digit = 7'b1001111;
      4'd4:    digit = 7'b1100110;
      4'd5:    digit = 7'b1101101;
      4'd6:    digit = 7'b1111101;
      4'd7:    digit = 7'b0000111;
      4'd8:    digit = 7'b1111111;
      4'd9:    digit = 7'b1101111;
      default: digit = 7'b0000000;
    endcase
  endfunction
`endif

  assign qualify = drop_en && (t_act <= t_lim);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_COLD;
      qual_cnt <= '0;
      hold_cnt <= '0;
      pkg_r    <= 4'(N_PKG);
    end else begin
      state    <= state_n;
      qual_cnt <= qual_n;
      hold_cnt <= hold_n;
      pkg_r    <= pkg_n;
    end
  end

  always_comb begin
    state_n        = state;
    qual_n         = qual_cnt;
    hold_n         = hold_cnt;
    pkg_n          = pkg_r;
    drop_activated = 1'b0;
    seven_seg1     = 7'b0111001;
    seven_seg2     = 7'b1011100;
    seven_seg3     = 7'b0111000;
    seven_seg4     = 7'b1011110;

    // DROP ignores every input, reload included; elsewhere reload beats qualification.
    if (state == S_DROP) begin
      if (hold_cnt == HW'(HOLD - 1)) begin
        hold_n  = '0;
        state_n = (pkg_r == 4'd0) ? S_EMPTY : S_WAIT_CLEAR;
      end else begin
        hold_n = hold_cnt + 1'b1;
      end
    end else if (reload) begin
      pkg_n   = 4'(N_PKG);
      qual_n  = '0;
      state_n = S_COLD;
    end else begin
      case (state)
        S_COLD, S_HOT, S_QUAL: begin
          // qual_cnt is zero in COLD/HOT, so QUAL==1 drops on the first sample.
          if (qualify && pkg_r != 4'd0) begin
            if (qual_cnt == QW'(QUAL - 1)) begin
              qual_n  = '0;
              hold_n  = '0;
              pkg_n   = pkg_r - 4'd1;
              state_n = S_DROP;
            end else begin
              qual_n  = qual_cnt + 1'b1;
              state_n = S_QUAL;
            end
          end else begin
            qual_n  = '0;
            state_n = drop_en ? S_HOT : S_COLD;
          end
        end
        S_WAIT_CLEAR: if (!drop_en) state_n = S_COLD;
        S_EMPTY:      state_n = S_EMPTY;
        default:      state_n = S_COLD;
      endcase
    end

    case (state)
      S_HOT, S_QUAL: begin
        seven_seg1 = 7'b0000000;
        seven_seg2 = 7'b1110110;
        seven_seg3 = 7'b1011100;
        seven_seg4 = 7'b1111000;
      end
      S_DROP: begin
        drop_activated = 1'b1;
        seven_seg1     = 7'b1011110;
        seven_seg2     = 7'b1010000;
        seven_seg3     = 7'b1011100;
        seven_seg4     = 7'b1110011;
      end
      S_WAIT_CLEAR: begin
`ifdef DROP_COUNT_DISP_EN
        seven_seg1 = 7'b1110011;
        seven_seg2 = 7'b1000000;
        seven_seg3 = 7'b0000000;
        seven_seg4 = digit(pkg_r);
`else
        seven_seg1 = 7'b1011110;
        seven_seg2 = 7'b1010000;
        seven_seg3 = 7'b1011100;
        seven_seg4 = 7'b1110011;
`endif
      end
      S_EMPTY: begin
        seven_seg1 = 7'b1011110;
        seven_seg2 = 7'b1011100;
        seven_seg3 = 7'b1010100;
        seven_seg4 = 7'b1111001;
      end
      default: ;
    endcase
  end

  assign pkg_left = pkg_r;

endmodule
